// File: rtl/router_sync_ctrl_if.sv
// Handshake bundle between the router input FSM, the three output FIFOs
// and the sync controller that glues them together.
interface router_sync_ctrl_if;
    logic       detect_add;
    logic [1:0] data_in;
    logic       write_enb_reg;
    logic       read_enb_0;
    logic       read_enb_1;
    logic       read_enb_2;
    logic       full_0;
    logic       full_1;
    logic       full_2;
    logic       empty_0;
    logic       empty_1;
    logic       empty_2;
    logic [2:0] write_enb;
    logic       fifo_full;
    logic       valid_out_0;
    logic       valid_out_1;
    logic       valid_out_2;
    logic       soft_reset_0;
    logic       soft_reset_1;
    logic       soft_reset_2;
    logic [1:0] dest_addr;

    // FSM / FIFO / receiver side
    modport master (
        output detect_add, data_in, write_enb_reg,
        output read_enb_0, read_enb_1, read_enb_2,
        output full_0, full_1, full_2,
        output empty_0, empty_1, empty_2,
        input  write_enb, fifo_full,
        input  valid_out_0, valid_out_1, valid_out_2,
        input  soft_reset_0, soft_reset_1, soft_reset_2,
        input  dest_addr
    );

    // Controller side
    modport slave (
        input  detect_add, data_in, write_enb_reg,
        input  read_enb_0, read_enb_1, read_enb_2,
        input  full_0, full_1, full_2,
        input  empty_0, empty_1, empty_2,
        output write_enb, fifo_full,
        output valid_out_0, valid_out_1, valid_out_2,
        output soft_reset_0, soft_reset_1, soft_reset_2,
        output dest_addr
    );
endinterface

// File: rtl/router_sync_ctrl.sv
// Router sync controller: latches the packet destination, steers the FSM
// write enable to the addressed FIFO, returns that FIFO's full flag, and
// watches each output for a receiver that stops draining it.
module router_sync_ctrl #(
    parameter int TIMEOUT = 30,
    parameter int CNT_W   = 5
) (
    input logic              clk,
    input logic              resetn,
    router_sync_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       dest_addr_r;
    logic [CNT_W-1:0] cnt_r [3];
    logic [2:0]       soft_reset_r;

    logic [2:0]       valid_s;
    logic [2:0]       read_s;
    logic [2:0]       full_s;
    logic [2:0]       stall_s;
    logic [2:0]       write_enb_s;
    logic             fifo_full_s;

    assign valid_s = ~{bus.empty_2, bus.empty_1, bus.empty_0};
    assign read_s  = {bus.read_enb_2, bus.read_enb_1, bus.read_enb_0};
    assign full_s  = {bus.full_2, bus.full_1, bus.full_0};
    // A receiver is stalling when data sits at its output and it is not reading.
    assign stall_s = valid_s & ~read_s;

    // Capture the header address while the FSM is decoding; 11 means no target.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dest_addr_r <= 2'b11;
        end else if (bus.detect_add) begin
            dest_addr_r <= bus.data_in;
        end else begin
            dest_addr_r <= dest_addr_r;
        end
    end

    // Route the single write request and pick the matching full flag from the latched address.
    always_comb begin
        write_enb_s = 3'b000;
        fifo_full_s = 1'b0;
        case (dest_addr_r)
            2'b00: begin
                write_enb_s = {2'b00, bus.write_enb_reg};
                fifo_full_s = full_s[0];
            end
            2'b01: begin
                write_enb_s = {1'b0, bus.write_enb_reg, 1'b0};
                fifo_full_s = full_s[1];
            end
            2'b10: begin
                write_enb_s = {bus.write_enb_reg, 2'b00};
                fifo_full_s = full_s[2];
            end
            default: begin
                write_enb_s = 3'b000;
                fifo_full_s = 1'b0;
            end
        endcase
    end

    // Per-output stall counters; the last stalled cycle fires a one-cycle soft reset and restarts the count.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < 3; k++) begin
                cnt_r[k] <= CNT_ZERO;
            end
            soft_reset_r <= 3'b000;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (stall_s[k]) begin
                    // >= keeps an out-of-range count from wrapping silently
                    if (cnt_r[k] >= CNT_LAST) begin
                        cnt_r[k]        <= CNT_ZERO;
                        soft_reset_r[k] <= 1'b1;
                    end else begin
                        cnt_r[k]        <= cnt_r[k] + CNT_ONE;
                        soft_reset_r[k] <= 1'b0;
                    end
                end else begin
                    cnt_r[k]        <= CNT_ZERO;
                    soft_reset_r[k] <= 1'b0;
                end
            end
        end
    end

    assign bus.write_enb    = write_enb_s;
    assign bus.fifo_full    = fifo_full_s;
    assign bus.valid_out_0  = valid_s[0];
    assign bus.valid_out_1  = valid_s[1];
    assign bus.valid_out_2  = valid_s[2];
    assign bus.soft_reset_0 = soft_reset_r[0];
    assign bus.soft_reset_1 = soft_reset_r[1];
    assign bus.soft_reset_2 = soft_reset_r[2];
    assign bus.dest_addr    = dest_addr_r;

endmodule

// File: tb/tb_router_sync_ctrl.sv
// Bench for router_sync_ctrl: a vector table for the address/steering path,
// hand sequences for the timeout corner cases, and a per-output queue of
// expected soft_reset cycles compared by a negedge monitor.
module tb_router_sync_ctrl;

    localparam int TIMEOUT = 30;

    logic clk;
    logic resetn;
    int   cyc;
    int   n_tests;
    int   n_fail;

    int   q0 [$];
    int   q1 [$];
    int   q2 [$];

    router_sync_ctrl_if ifc ();

    router_sync_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (ifc.slave)
    );

    typedef struct {
        logic       da;
        logic [1:0] din;
        logic       wr;
        logic [2:0] full;
        logic [2:0] empty;
        logic [1:0] exp_dest;
        logic [2:0] exp_we;
        logic       exp_ff;
        logic [2:0] exp_valid;
    } vec_t;

    vec_t vecs [11];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s at cyc %0d: got %0h, want %0h", name, cyc, got, want);
        end
    endtask

    // Compare one soft_reset output against the front of its expected queue.
    task automatic chk_pulse(input int k, input logic act);
        logic exp_b;
        exp_b = 1'b0;
        case (k)
            0: if (q0.size() > 0 && q0[0] == cyc) begin exp_b = 1'b1; void'(q0.pop_front()); end
            1: if (q1.size() > 0 && q1[0] == cyc) begin exp_b = 1'b1; void'(q1.pop_front()); end
            default: if (q2.size() > 0 && q2[0] == cyc) begin exp_b = 1'b1; void'(q2.pop_front()); end
        endcase
        if (exp_b || act) begin
            n_tests++;
            if (act !== exp_b) begin
                n_fail++;
                $display("FAIL soft_reset_%0d at cyc %0d: got %b, want %b", k, cyc, act, exp_b);
            end
        end
    endtask

    // Scoreboard monitor sampling pulses mid-cycle.
    always @(negedge clk) begin
        chk_pulse(0, ifc.soft_reset_0);
        chk_pulse(1, ifc.soft_reset_1);
        chk_pulse(2, ifc.soft_reset_2);
    end

    // Move to the driving point of a later cycle (just after a falling edge).
    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        resetn  = 1'b0;
        ifc.detect_add    = 1'b0;
        ifc.data_in       = 2'b00;
        ifc.write_enb_reg = 1'b1;
        ifc.read_enb_0    = 1'b1;
        ifc.read_enb_1    = 1'b1;
        ifc.read_enb_2    = 1'b1;
        {ifc.full_2, ifc.full_1, ifc.full_0}    = 3'b111;
        {ifc.empty_2, ifc.empty_1, ifc.empty_0} = 3'b111;

        //              da    din    wr    full    empty   dest   we      ff    valid
        vecs[0]  = '{1'b0, 2'b00, 1'b1, 3'b000, 3'b111, 2'b11, 3'b000, 1'b0, 3'b000};
        vecs[1]  = '{1'b1, 2'b01, 1'b0, 3'b000, 3'b110, 2'b01, 3'b000, 1'b0, 3'b001};
        vecs[2]  = '{1'b0, 2'b00, 1'b1, 3'b000, 3'b101, 2'b01, 3'b010, 1'b0, 3'b010};
        vecs[3]  = '{1'b0, 2'b00, 1'b1, 3'b010, 3'b011, 2'b01, 3'b010, 1'b1, 3'b100};
        vecs[4]  = '{1'b0, 2'b00, 1'b1, 3'b001, 3'b111, 2'b01, 3'b010, 1'b0, 3'b000};
        vecs[5]  = '{1'b1, 2'b11, 1'b0, 3'b000, 3'b111, 2'b11, 3'b000, 1'b0, 3'b000};
        vecs[6]  = '{1'b0, 2'b00, 1'b1, 3'b111, 3'b000, 2'b11, 3'b000, 1'b0, 3'b111};
        vecs[7]  = '{1'b1, 2'b10, 1'b1, 3'b100, 3'b111, 2'b10, 3'b100, 1'b1, 3'b000};
        vecs[8]  = '{1'b0, 2'b01, 1'b1, 3'b011, 3'b111, 2'b10, 3'b100, 1'b0, 3'b000};
        vecs[9]  = '{1'b1, 2'b00, 1'b1, 3'b001, 3'b111, 2'b00, 3'b001, 1'b1, 3'b000};
        vecs[10] = '{1'b0, 2'b00, 1'b0, 3'b001, 3'b111, 2'b00, 3'b000, 1'b1, 3'b000};

        // Reset state, with a write request and every full flag asserted.
        wait_n(2);
        chk("reset dest_addr", ifc.dest_addr, 2'b11);
        chk("reset write_enb", ifc.write_enb, 3'b000);
        chk("reset fifo_full", ifc.fifo_full, 1'b0);
        chk("reset soft_reset", {ifc.soft_reset_2, ifc.soft_reset_1, ifc.soft_reset_0}, 3'b000);
        resetn = 1'b1;

        // Address latch and steering table, receivers always reading.
        for (int i = 0; i < 11; i++) begin
            wait_n(1);
            ifc.detect_add    = vecs[i].da;
            ifc.data_in       = vecs[i].din;
            ifc.write_enb_reg = vecs[i].wr;
            {ifc.full_2, ifc.full_1, ifc.full_0}    = vecs[i].full;
            {ifc.empty_2, ifc.empty_1, ifc.empty_0} = vecs[i].empty;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d dest_addr", i), ifc.dest_addr, vecs[i].exp_dest);
            chk($sformatf("v%0d write_enb", i), ifc.write_enb, vecs[i].exp_we);
            chk($sformatf("v%0d fifo_full", i), ifc.fifo_full, vecs[i].exp_ff);
            chk($sformatf("v%0d valid_out", i),
                {ifc.valid_out_2, ifc.valid_out_1, ifc.valid_out_0}, vecs[i].exp_valid);
        end

        // detect_add and write in the same cycle: old address first, new one next cycle.
        wait_n(1);
        ifc.detect_add    = 1'b1;
        ifc.data_in       = 2'b10;
        ifc.write_enb_reg = 1'b1;
        #1;
        chk("same-cycle old addr", ifc.write_enb, 3'b001);
        @(posedge clk);
        #1;
        chk("same-cycle new dest", ifc.dest_addr, 2'b10);
        chk("same-cycle new addr", ifc.write_enb, 3'b100);

        wait_n(1);
        ifc.detect_add    = 1'b0;
        ifc.write_enb_reg = 1'b0;
        {ifc.full_2, ifc.full_1, ifc.full_0}    = 3'b000;
        {ifc.empty_2, ifc.empty_1, ifc.empty_0} = 3'b111;
        ifc.read_enb_0 = 1'b0;
        ifc.read_enb_1 = 1'b0;
        ifc.read_enb_2 = 1'b0;
        wait_n(2);

        // Output 2 stalled: one pulse after 30 stalled cycles.
        ifc.empty_2 = 1'b0;
        q2.push_back(cyc + TIMEOUT);
        wait_n(35);
        ifc.empty_2 = 1'b1;
        wait_n(2);

        // Output 2 stalled, single read at stalled cycle 29 restarts the count.
        ifc.empty_2 = 1'b0;
        wait_n(28);
        ifc.read_enb_2 = 1'b1;
        wait_n(1);
        ifc.read_enb_2 = 1'b0;
        q2.push_back(cyc + TIMEOUT);
        wait_n(32);
        ifc.empty_2 = 1'b1;
        wait_n(2);

        // Outputs 0 and 1 stalled together and held: simultaneous pulses, repeated 30 cycles later.
        ifc.empty_0 = 1'b0;
        ifc.empty_1 = 1'b0;
        q0.push_back(cyc + TIMEOUT);
        q0.push_back(cyc + 2 * TIMEOUT);
        q1.push_back(cyc + TIMEOUT);
        q1.push_back(cyc + 2 * TIMEOUT);
        wait_n(62);
        ifc.empty_0 = 1'b1;
        ifc.empty_1 = 1'b1;
        wait_n(2);

        // Reset mid-count and mid-packet.
        ifc.detect_add = 1'b1;
        ifc.data_in    = 2'b10;
        wait_n(1);
        ifc.detect_add = 1'b0;
        ifc.empty_1    = 1'b0;
        q1.push_back(cyc + TIMEOUT);
        wait_n(20);
        ifc.write_enb_reg = 1'b1;
        #1;
        chk("pre-reset write_enb", ifc.write_enb, 3'b100);
        chk("pre-reset dest_addr", ifc.dest_addr, 2'b10);
        resetn = 1'b0;
        q1.delete();
        #1;
        chk("mid-reset write_enb", ifc.write_enb, 3'b000);
        chk("mid-reset dest_addr", ifc.dest_addr, 2'b11);
        chk("mid-reset soft_reset", {ifc.soft_reset_2, ifc.soft_reset_1, ifc.soft_reset_0}, 3'b000);
        wait_n(3);
        resetn = 1'b1;
        q1.push_back(cyc + TIMEOUT);
        #1;
        chk("post-reset write_enb", ifc.write_enb, 3'b000);
        wait_n(32);
        ifc.empty_1       = 1'b1;
        ifc.write_enb_reg = 1'b0;
        wait_n(3);

        chk("pending pulses", q0.size() + q1.size() + q2.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/router_sync_ctrl.md
Name: router_sync_ctrl

Overview:
- Glue controller between the router input FSM and the three output FIFOs.
- Latches the packet destination address when the FSM is in its decode state, and steers the FSM's single write-enable to the one addressed FIFO.
- Muxes the addressed FIFO's full flag back to the FSM and generates per-output valid_out.
- Runs three independent read-timeout counters that issue a one-cycle soft_reset to the FSM and FIFO when a receiver does not drain its output within TIMEOUT cycles.

Parameters:
- TIMEOUT, 30: consecutive stalled cycles (valid_out high, read_enb low) before soft_reset fires.
- CNT_W, 5: timeout counter width; 2^CNT_W must be greater than TIMEOUT.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- resetn  input  1  asynchronous active-low reset
- detect_add  input  1  FSM in address-decode state; capture data_in
- data_in  input  2  header address bits; 00/01/10 valid, 11 invalid
- write_enb_reg  input  1  FSM write request for the current packet byte
- read_enb_0, read_enb_1, read_enb_2  input  1 each  receiver read strobes
- full_0, full_1, full_2  input  1 each  FIFO full flags
- empty_0, empty_1, empty_2  input  1 each  FIFO empty flags
- write_enb  output  3  one-hot FIFO write enables
- fifo_full  output  1  full flag of the addressed FIFO
- valid_out_0, valid_out_1, valid_out_2  output  1 each  data available at output k
- soft_reset_0, soft_reset_1, soft_reset_2  output  1 each  registered one-cycle timeout pulses
- dest_addr  output  2  latched destination address

Behaviour:

Reset (resetn low, asynchronous):
- dest_addr = 2'b11.
- All three counters = 0.
- soft_reset_0/1/2 = 0.
- Combinational outputs follow from these values: write_enb = 000, fifo_full = 0.
- Reset mid-packet drops the latched address immediately; no write reaches any FIFO until a new detect_add.

Address latch:
- On a rising clk edge with detect_add=1, dest_addr <= data_in; otherwise dest_addr holds.
- data_in=11 is latched as-is; it means "no target".

write_enb (combinational from registered dest_addr):
- write_enb_reg=1 and dest_addr 00 -> 001; 01 -> 010; 10 -> 100.
- Otherwise 000, including dest_addr=11.
- If detect_add and write_enb_reg are high in the same cycle, the previously latched address is used. The new address applies from the next cycle.

fifo_full (combinational):
- Selects full_0, full_1 or full_2 by dest_addr.
- dest_addr=11 -> 0.

valid_out_k (combinational):
- valid_out_k = ~empty_k.

Timeout counter k (identical and independent for k=0,1,2):
- Stall condition: valid_out_k=1 and read_enb_k=0.
- Stall this cycle and cnt_k < TIMEOUT-1: cnt_k <= cnt_k+1; soft_reset_k <= 0.
- Stall this cycle and cnt_k == TIMEOUT-1: soft_reset_k <= 1; cnt_k <= 0.
- No stall (read_enb_k=1 or valid_out_k=0): cnt_k <= 0; soft_reset_k <= 0.
- Effect: soft_reset_k is high for exactly one cycle, beginning at the edge that ends the TIMEOUT-th consecutive stalled cycle.
- A single cycle with read_enb_k high restarts the count from 0.
- If the stall continues after the pulse (FIFO not yet flushed), counting restarts from 0. The next pulse comes TIMEOUT cycles later, never back-to-back.
- Multiple outputs may time out in the same cycle. All of their pulses are asserted independently.
- soft_reset does not modify dest_addr.

Latency:
- write_enb, fifo_full and valid_out: 0 cycles (combinational).
- dest_addr: 1 cycle after detect_add.
- soft_reset: registered, as described above.

Test Plan:
1. Reset, then detect_add=1 with data_in=01 for one cycle, then write_enb_reg=1 -> dest_addr=01, write_enb=010; full_1=1 gives fifo_full=1; full_0=1 alone gives fifo_full=0.
2. detect_add with data_in=11, then write_enb_reg=1 and full_0/1/2 all 1 -> write_enb=000, fifo_full=0.
3. empty_2=0 and read_enb_2=0 held (TIMEOUT=30) -> soft_reset_2 rises at the edge ending stalled cycle 30, lasts exactly 1 cycle; soft_reset_0/1 stay 0.
4. Same as 3, but read_enb_2 pulsed high for one cycle at stalled cycle 29 -> no pulse at 30; the pulse occurs 30 stalled cycles after the read.
5. empty_0=0 and empty_1=0, both unread from the same cycle -> soft_reset_0 and soft_reset_1 pulse in the same cycle; stall held afterwards -> second pulses exactly 30 cycles later.
6. resetn asserted low mid-count (cnt_1=20) and mid-packet (dest_addr=10, write_enb_reg=1) -> immediately write_enb=000, dest_addr=11, counters 0, no soft_reset; after release, a 30-cycle stall is needed before the next pulse.
